// File: rtl/input_line_ctrl_pkg.sv
// Shared widths, control characters and FSM encoding for the UART input line controller.
package input_line_ctrl_pkg;

  localparam int unsigned DataW = 8;
  localparam int unsigned Depth = 15;
  localparam int unsigned CntW  = 4;

  localparam logic [DataW-1:0] ChCr  = 8'h0D;
  localparam logic [DataW-1:0] ChBs  = 8'h08;
  localparam logic [DataW-1:0] ChDel = 8'h7F;

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [0:0] {
    StCollect = 1'b0,
    StPending = 1'b1
  } state_e;

  function automatic logic is_backspace(input logic [DataW-1:0] b);
    return (b == ChBs) || (b == ChDel);
  endfunction

endpackage

// File: rtl/input_line_ctrl_rise_detect.sv
// Rising-edge detector; the reset value of the history bit sets whether a level held
// high through reset is reported as an edge.
module input_line_ctrl_rise_detect #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic strobe_o
);

  logic level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= ResetVal;
    end else begin
      level_q <= level_i;
    end
  end

  assign strobe_o = level_i & ~level_q;

endmodule

// File: rtl/input_line_ctrl.sv
// Line-editing controller: turns received bytes into push/pop/clear commands for the input
// queue and hands CR-terminated lines to the parser over a valid/ack handshake.
module input_line_ctrl
  import input_line_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DataW-1:0] data_in,
  input  logic             received,
  input  logic             cmd_ack,
  output logic             q_push,
  output logic             q_pop,
  output logic             q_clear,
  output logic [DataW-1:0] q_data,
  output logic [CntW-1:0]  char_count,
  output logic             cmd_valid,
  output logic [CntW-1:0]  cmd_len,
  output logic             overflow,
  output logic             drop
);

  logic strobe;

  input_line_ctrl_rise_detect #(
    .ResetVal (1'b1)
  ) u_rise_detect (
    .clk      (clk),
    .rst      (rst),
    .level_i  (received),
    .strobe_o (strobe)
  );

  state_e           state_q;
  logic             push_q, pop_q, clear_q, drop_q, valid_q, ovf_q;
  logic [DataW-1:0] data_q;
  logic [CntW-1:0]  count_q, len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StCollect;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      clear_q <= 1'b0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      clear_q <= 1'b0;
      drop_q  <= 1'b0;
      unique case (state_q)
        StCollect: begin
          if (strobe) begin
            if (data_in == ChCr) begin
              if (count_q != '0) begin
                valid_q <= 1'b1;
                len_q   <= count_q;
                state_q <= StPending;
              end
            end else if (is_backspace(data_in)) begin
              if (count_q != '0) begin
                pop_q   <= 1'b1;
                count_q <= count_q - CntOne;
              end
            end else if (count_q < DepthCnt) begin
              push_q  <= 1'b1;
              data_q  <= data_in;
              count_q <= count_q + CntOne;
            end else begin
              drop_q <= 1'b1;
              ovf_q  <= 1'b1;
            end
          end
        end
        StPending: begin
          // Queue is frozen until the parser acks; any byte arriving now is lost.
          drop_q <= strobe;
          if (cmd_ack) begin
            clear_q <= 1'b1;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            len_q   <= '0;
            state_q <= StCollect;
          end
        end
        default: state_q <= StCollect;
      endcase
    end
  end

  assign q_push     = push_q;
  assign q_pop      = pop_q;
  assign q_clear    = clear_q;
  assign q_data     = data_q;
  assign char_count = count_q;
  assign cmd_valid  = valid_q;
  assign cmd_len    = len_q;
  assign overflow   = ovf_q;
  assign drop       = drop_q;

endmodule
